// File: rtl/mmio_bus_mux.sv
// CPU-side memory interconnect: mask/match address decode to one-hot chip selects,
// registered response, per-access ready timeout and sticky error capture.
module mmio_bus_mux #(
  parameter int                        NUM_SLAVES     = 8,
  parameter int                        ADDR_WIDTH     = 15,
  parameter logic [8*NUM_SLAVES-1:0]   SLAVE_MATCH    = {NUM_SLAVES{8'h00}},
  parameter logic [8*NUM_SLAVES-1:0]   SLAVE_MASK     = {NUM_SLAVES{8'hff}},
  parameter int                        TIMEOUT_CYCLES = 255,
  parameter int                        TO_WIDTH       = 8,
  parameter logic [31:0]               ERR_RDATA      = 32'h0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cpu_valid,
  input  logic [31:0]                  cpu_addr,
  input  logic [3:0]                   cpu_wstrb,
  input  logic [31:0]                  cpu_wdata,
  output logic                         cpu_ready,
  output logic [31:0]                  cpu_rdata,
  output logic [NUM_SLAVES-1:0]        slv_cs,
  output logic                         slv_we,
  output logic [3:0]                   slv_wstrb,
  output logic [ADDR_WIDTH-1:0]        slv_address,
  output logic [31:0]                  slv_write_data,
  input  logic [32*NUM_SLAVES-1:0]     slv_read_data,
  input  logic [NUM_SLAVES-1:0]        slv_ready,
  input  logic                         err_clear,
  output logic                         err_valid,
  output logic [1:0]                   err_code,
  output logic [31:0]                  err_addr,
  output logic                         err_overflow
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [TO_WIDTH-1:0]  cnt, cnt_nxt;
  logic [IDX_W-1:0]     sel, sel_nxt;
  logic [31:0]          rdata_nxt;
  logic                 hit_any;
  logic [IDX_W-1:0]     hit_idx;
  logic [IDX_W-1:0]     act_idx;
  logic [31:0]          act_rdata;
  logic                 act_ready;
  logic                 cs_en;
  logic [NUM_SLAVES-1:0] cs_vec;
  logic                 err_evt;
  logic [1:0]           err_evt_code;

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((cpu_addr[31:24] & SLAVE_MASK[8*i +: 8]) == SLAVE_MATCH[8*i +: 8]) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign act_idx = (state == S_WAIT) ? sel : hit_idx;

  always_comb begin
    act_rdata = '0;
    act_ready = 1'b0;
    cs_vec    = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (act_idx == IDX_W'(i)) begin
        act_rdata = slv_read_data[32*i +: 32];
        act_ready = slv_ready[i];
        cs_vec[i] = cs_en;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    sel_nxt      = sel;
    rdata_nxt    = cpu_rdata;
    cs_en        = 1'b0;
    err_evt      = 1'b0;
    err_evt_code = 2'b00;
    case (state)
      S_IDLE: begin
        if (cpu_valid) begin
          if (hit_any) begin
            cs_en   = 1'b1;
            sel_nxt = hit_idx;
            if (act_ready) begin
              rdata_nxt = act_rdata;
              state_nxt = S_RESP;
            end else begin
              cnt_nxt   = TO_WIDTH'(1);
              state_nxt = S_WAIT;
            end
          end else begin
            rdata_nxt    = ERR_RDATA;
            err_evt      = 1'b1;
            err_evt_code = 2'b01;
            state_nxt    = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (!cpu_valid) begin
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end else begin
          // The select is already released in the cycle the timeout expires.
          cs_en = (cnt != TO_LIMIT);
          if (act_ready) begin
            rdata_nxt = act_rdata;
            cnt_nxt   = '0;
            state_nxt = S_RESP;
          end else if (cnt == TO_LIMIT) begin
            rdata_nxt    = ERR_RDATA;
            err_evt      = 1'b1;
            err_evt_code = 2'b10;
            cnt_nxt      = '0;
            state_nxt    = S_RESP;
          end else begin
            cnt_nxt = cnt + TO_WIDTH'(1);
          end
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      sel       <= '0;
      cpu_ready <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      sel       <= sel_nxt;
      cpu_ready <= (state_nxt == S_RESP);
      cpu_rdata <= rdata_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_valid    <= 1'b0;
      err_code     <= 2'b00;
      err_addr     <= '0;
      err_overflow <= 1'b0;
    end else if (err_clear) begin
      err_valid    <= err_evt;
      err_code     <= err_evt ? err_evt_code : 2'b00;
      err_addr     <= err_evt ? cpu_addr : 32'h0;
      err_overflow <= 1'b0;
    end else if (err_evt) begin
      if (!err_valid) begin
        err_valid <= 1'b1;
        err_code  <= err_evt_code;
        err_addr  <= cpu_addr;
      end else begin
        err_overflow <= 1'b1;
      end
    end
  end

  // Selects must fall as soon as reset rises, even with a request still on the bus.
  assign slv_cs         = reset ? '0 : cs_vec;
  assign slv_we         = ~reset & (|cpu_wstrb);
  assign slv_wstrb      = reset ? 4'h0 : cpu_wstrb;
  assign slv_address    = reset ? '0 : cpu_addr[ADDR_WIDTH+1:2];
  assign slv_write_data = reset ? 32'h0 : cpu_wdata;

endmodule

// File: tb/tb_mmio_bus_mux.sv
// Bench for mmio_bus_mux: decode vector table, directed multi-cycle sequences and
// randomized traffic checked against a transaction-level reference model.
module tb_mmio_bus_mux;

  localparam int NS = 4;
  localparam int AW = 15;
  localparam int TO = 4;
  localparam logic [31:0] ERR_RD = 32'h0;
  localparam logic [7:0] MATCH_T [NS] = '{8'h00, 8'h40, 8'h40, 8'hc3};
  localparam logic [7:0] MASK_T  [NS] = '{8'hc0, 8'hf0, 8'hc0, 8'hff};
  localparam logic [7:0] TOPS    [14] = '{8'h00, 8'h1f, 8'h3f, 8'h40, 8'h4f, 8'h50, 8'h7f,
                                          8'h80, 8'hbf, 8'hc0, 8'hc2, 8'hc3, 8'hc4, 8'hff};
  localparam logic [32*NS-1:0] TBL_RD = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h1234_5678};

  logic clk, reset;
  logic cpu_valid, cpu_ready, slv_we, err_clear, err_valid, err_overflow;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, slv_write_data, err_addr;
  logic [3:0] cpu_wstrb, slv_wstrb;
  logic [NS-1:0] slv_cs, slv_ready;
  logic [AW-1:0] slv_address;
  logic [32*NS-1:0] slv_read_data;
  logic [1:0] err_code;

  mmio_bus_mux #(
    .NUM_SLAVES(NS), .ADDR_WIDTH(AW),
    .SLAVE_MATCH(32'hc340_4000), .SLAVE_MASK(32'hffc0_f0c0),
    .TIMEOUT_CYCLES(TO), .TO_WIDTH(8), .ERR_RDATA(ERR_RD)
  ) dut (
    .clk(clk), .reset(reset), .cpu_valid(cpu_valid), .cpu_addr(cpu_addr),
    .cpu_wstrb(cpu_wstrb), .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready),
    .cpu_rdata(cpu_rdata), .slv_cs(slv_cs), .slv_we(slv_we), .slv_wstrb(slv_wstrb),
    .slv_address(slv_address), .slv_write_data(slv_write_data),
    .slv_read_data(slv_read_data), .slv_ready(slv_ready), .err_clear(err_clear),
    .err_valid(err_valid), .err_code(err_code), .err_addr(err_addr),
    .err_overflow(err_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: outstanding access, its age in select cycles, pending response
  logic        m_resp, m_busy;
  logic [31:0] m_rdata;
  int          m_slv, m_age;
  logic        m_err_valid, m_err_ovf;
  logic [1:0]  m_err_code;
  logic [31:0] m_err_addr;
  logic        last_exp_ready;

  logic [NS-1:0] obs_cs;
  logic          obs_ready, obs_err_valid, obs_err_ovf, obs_we;
  logic [31:0]   obs_rdata, obs_err_addr, obs_wdata;
  logic [1:0]    obs_err_code;
  logic [AW-1:0] obs_address;

  typedef struct {
    logic [31:0]   addr;
    logic [3:0]    wstrb;
    logic [31:0]   wdata;
    logic [NS-1:0] exp_cs;
    logic [AW-1:0] exp_address;
    logic [31:0]   exp_rdata;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if ((a[31:24] & MASK_T[i]) == MATCH_T[i]) return i;
    return -1;
  endfunction

  function automatic logic [32*NS-1:0] random_rd();
    logic [32*NS-1:0] r;
    for (int i = 0; i < NS; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [7:0] pick_top();
    int idx;
    idx = $urandom_range(0, 14);
    if (idx == 14) return 8'($urandom);
    return TOPS[idx];
  endfunction

  task automatic model_reset();
    m_resp = 1'b0; m_busy = 1'b0; m_rdata = '0; m_slv = 0; m_age = 0;
    m_err_valid = 1'b0; m_err_ovf = 1'b0; m_err_code = 2'b00; m_err_addr = '0;
    last_exp_ready = 1'b0;
  endtask

  // Called just after a rising edge; drives one cycle, checks it, advances the model.
  task automatic cycle(input logic v, input logic [31:0] a, input logic [3:0] ws,
                       input logic [31:0] wd, input logic [NS-1:0] rdy, input logic ec,
                       input logic [32*NS-1:0] rd);
    logic [NS-1:0] e_cs;
    logic          n_resp, n_busy;
    logic [31:0]   n_rdata;
    int            n_slv, n_age, k;
    logic [1:0]    ev;
    cpu_valid = v; cpu_addr = a; cpu_wstrb = ws; cpu_wdata = wd;
    slv_ready = rdy; err_clear = ec; slv_read_data = rd;
    #2;
    e_cs = '0; n_resp = 1'b0; n_rdata = m_rdata; n_busy = m_busy;
    n_slv = m_slv; n_age = m_age; ev = 2'b00;
    if (m_resp) begin
      n_busy = 1'b0;
    end else if (!m_busy) begin
      if (v) begin
        k = decode(a);
        if (k >= 0) begin
          e_cs[k] = 1'b1;
          if (rdy[k]) begin
            n_resp = 1'b1; n_rdata = rd[32*k +: 32];
          end else begin
            n_busy = 1'b1; n_slv = k; n_age = 1;
          end
        end else begin
          n_resp = 1'b1; n_rdata = ERR_RD; ev = 2'b01;
        end
      end
    end else if (!v) begin
      n_busy = 1'b0;
    end else begin
      if (m_age < TO) e_cs[m_slv] = 1'b1;
      if (rdy[m_slv]) begin
        n_resp = 1'b1; n_rdata = rd[32*m_slv +: 32]; n_busy = 1'b0;
      end else if (m_age >= TO) begin
        n_resp = 1'b1; n_rdata = ERR_RD; ev = 2'b10; n_busy = 1'b0;
      end else begin
        n_age = m_age + 1;
      end
    end
    obs_cs = slv_cs; obs_ready = cpu_ready; obs_rdata = cpu_rdata;
    obs_err_valid = err_valid; obs_err_code = err_code; obs_err_addr = err_addr;
    obs_err_ovf = err_overflow; obs_we = slv_we; obs_address = slv_address;
    obs_wdata = slv_write_data;
    chk("cs", 64'(obs_cs), 64'(e_cs));
    chk("cpu_ready", 64'(obs_ready), 64'(m_resp));
    if (m_resp) chk("cpu_rdata", 64'(obs_rdata), 64'(m_rdata));
    chk("err_state", 64'({obs_err_valid, obs_err_code, obs_err_ovf, obs_err_addr}),
        64'({m_err_valid, m_err_code, m_err_ovf, m_err_addr}));
    chk("slv_passthru", 64'({slv_we, slv_wstrb, slv_address, slv_write_data}),
        64'({|ws, ws, a[AW+1:2], wd}));
    last_exp_ready = m_resp;
    @(posedge clk);
    #1;
    if (ec) begin
      m_err_ovf = 1'b0;
      if (ev != 2'b00) begin
        m_err_valid = 1'b1; m_err_code = ev; m_err_addr = a;
      end else begin
        m_err_valid = 1'b0; m_err_code = 2'b00; m_err_addr = '0;
      end
    end else if (ev != 2'b00) begin
      if (!m_err_valid) begin
        m_err_valid = 1'b1; m_err_code = ev; m_err_addr = a;
      end else begin
        m_err_ovf = 1'b1;
      end
    end
    m_resp = n_resp; m_rdata = n_rdata; m_busy = n_busy; m_slv = n_slv; m_age = n_age;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cpu_valid = 1'b0; cpu_addr = '0; cpu_wstrb = '0; cpu_wdata = '0;
    slv_ready = '0; err_clear = 1'b0; slv_read_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cs", 64'(slv_cs), 64'(0));
    chk("rst_ready", 64'(cpu_ready), 64'(0));
    chk("rst_rdata", 64'(cpu_rdata), 64'(0));
    chk("rst_err", 64'({err_valid, err_code, err_overflow, err_addr}), 64'(0));
    model_reset();
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    vec_t vt [9];
    int held, cs_cnt, rdy_cnt;
    logic done, rq, ec;
    logic [31:0] ra, rwd, last_rdata;
    logic [3:0] rws;
    logic [NS-1:0] rdy;

    vt[0] = '{32'h0000_0010, 4'h0, 32'h0,          4'b0001, 15'h0004, 32'h1234_5678};
    vt[1] = '{32'h3fff_fffc, 4'hf, 32'h0bad_cafe,  4'b0001, 15'h7fff, 32'h1234_5678};
    vt[2] = '{32'h4000_0020, 4'h0, 32'h0,          4'b0010, 15'h0008, 32'h1111_1111};
    vt[3] = '{32'h5000_0004, 4'h3, 32'h5555_aaaa,  4'b0100, 15'h0001, 32'h2222_2222};
    vt[4] = '{32'h7f00_0000, 4'h0, 32'h0,          4'b0100, 15'h0000, 32'h2222_2222};
    vt[5] = '{32'hc300_0008, 4'h1, 32'h0000_00a5,  4'b1000, 15'h0002, 32'h3333_3333};
    vt[6] = '{32'h8000_0000, 4'h0, 32'h0,          4'b0000, 15'h0000, 32'h0};
    vt[7] = '{32'hc200_0004, 4'h0, 32'h0,          4'b0000, 15'h0001, 32'h0};
    vt[8] = '{32'hc400_0000, 4'hf, 32'h1,          4'b0000, 15'h0000, 32'h0};

    do_reset();

    // decode table, every slave answers immediately
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, vt[i].addr, vt[i].wstrb, vt[i].wdata, 4'hf, 1'b0, TBL_RD);
      chk($sformatf("tbl%0d_cs", i), 64'(obs_cs), 64'(vt[i].exp_cs));
      chk($sformatf("tbl%0d_address", i), 64'(obs_address), 64'(vt[i].exp_address));
      cycle(1'b1, vt[i].addr, vt[i].wstrb, vt[i].wdata, 4'hf, 1'b0, TBL_RD);
      chk($sformatf("tbl%0d_ready", i), 64'(obs_ready), 64'(1));
      chk($sformatf("tbl%0d_rdata", i), 64'(obs_rdata), 64'(vt[i].exp_rdata));
      cycle(1'b0, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0, TBL_RD);
    end

    // slave 3 with three cycles of ready latency
    cycle(1'b0, 32'h0, 4'h0, 32'h0, 4'h0, 1'b1, random_rd());
    held = 0; cs_cnt = 0; rdy_cnt = 0; done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle(!done, 32'hc300_0008, 4'hf, 32'hcafe_f00d, (held >= 3) ? 4'b1000 : 4'b0000,
            1'b0, random_rd());
      if (i == 0) begin
        chk("wr_we", 64'(obs_we), 64'(1));
        chk("wr_address", 64'(obs_address), 64'(2));
        chk("wr_wdata", 64'(obs_wdata), 64'(32'hcafe_f00d));
      end
      if (obs_cs == 4'b1000) begin held++; cs_cnt++; end
      if (obs_ready) begin rdy_cnt++; done = 1'b1; end
    end
    chk("wr_cs_cycles", 64'(cs_cnt), 64'(4));
    chk("wr_ready_pulses", 64'(rdy_cnt), 64'(1));

    // timeout on a slave that never answers
    cycle(1'b0, 32'h0, 4'h0, 32'h0, 4'h0, 1'b1, random_rd());
    cs_cnt = 0; rdy_cnt = 0; done = 1'b0; last_rdata = 32'hffff_ffff;
    for (int i = 0; i < 12; i++) begin
      cycle(!done, 32'h0000_0100, 4'h0, 32'h0, 4'h0, 1'b0, random_rd());
      if (obs_cs != '0) cs_cnt++;
      if (obs_ready) begin rdy_cnt++; done = 1'b1; last_rdata = obs_rdata; end
    end
    chk("to_cs_cycles", 64'(cs_cnt), 64'(4));
    chk("to_ready_pulses", 64'(rdy_cnt), 64'(1));
    chk("to_rdata", 64'(last_rdata), 64'(ERR_RD));
    chk("to_err", 64'({obs_err_valid, obs_err_code, obs_err_ovf, obs_err_addr}),
        64'({1'b1, 2'b10, 1'b0, 32'h0000_0100}));

    // unmapped accesses, overflow, clear, and clear colliding with a new error
    cycle(1'b0, 32'h0, 4'h0, 32'h0, 4'h0, 1'b1, random_rd());
    cycle(1'b1, 32'hc500_0000, 4'h0, 32'h0, 4'hf, 1'b0, random_rd());
    chk("um_cs", 64'(obs_cs), 64'(0));
    cycle(1'b1, 32'hc500_0000, 4'h0, 32'h0, 4'hf, 1'b0, random_rd());
    chk("um_ready", 64'(obs_ready), 64'(1));
    chk("um_rdata", 64'(obs_rdata), 64'(0));
    chk("um_err", 64'({obs_err_valid, obs_err_code, obs_err_ovf, obs_err_addr}),
        64'({1'b1, 2'b01, 1'b0, 32'hc500_0000}));
    cycle(1'b0, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0, random_rd());
    cycle(1'b1, 32'h9000_0000, 4'h0, 32'h0, 4'hf, 1'b0, random_rd());
    cycle(1'b1, 32'h9000_0000, 4'h0, 32'h0, 4'hf, 1'b0, random_rd());
    chk("um_overflow", 64'({obs_err_valid, obs_err_code, obs_err_ovf, obs_err_addr}),
        64'({1'b1, 2'b01, 1'b1, 32'hc500_0000}));
    cycle(1'b0, 32'h0, 4'h0, 32'h0, 4'h0, 1'b1, random_rd());
    cycle(1'b0, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0, random_rd());
    chk("um_cleared", 64'({obs_err_valid, obs_err_code, obs_err_ovf, obs_err_addr}), 64'(0));
    cycle(1'b1, 32'h8000_0000, 4'h0, 32'h0, 4'hf, 1'b0, random_rd());
    cycle(1'b1, 32'h8000_0000, 4'h0, 32'h0, 4'hf, 1'b0, random_rd());
    cycle(1'b0, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0, random_rd());
    cycle(1'b1, 32'hff00_0004, 4'h0, 32'h0, 4'hf, 1'b1, random_rd());
    cycle(1'b1, 32'hff00_0004, 4'h0, 32'h0, 4'hf, 1'b0, random_rd());
    chk("um_clear_collide", 64'({obs_err_valid, obs_err_code, obs_err_ovf, obs_err_addr}),
        64'({1'b1, 2'b01, 1'b0, 32'hff00_0004}));
    cycle(1'b0, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0, random_rd());

    // asynchronous reset while waiting on a slave
    cycle(1'b1, 32'h0000_0200, 4'h0, 32'h0, 4'h0, 1'b0, random_rd());
    cycle(1'b1, 32'h0000_0200, 4'h0, 32'h0, 4'h0, 1'b0, random_rd());
    cpu_valid = 1'b1; slv_ready = '0;
    #1;
    chk("ar_cs_before", 64'(slv_cs), 64'(1));
    reset = 1'b1;
    #1;
    chk("ar_cs_async", 64'(slv_cs), 64'(0));
    chk("ar_ready_async", 64'(cpu_ready), 64'(0));
    do_reset();
    cycle(1'b1, 32'h0000_0040, 4'h0, 32'h0, 4'hf, 1'b0, random_rd());
    cycle(1'b1, 32'h0000_0040, 4'h0, 32'h0, 4'hf, 1'b0, random_rd());
    chk("ar_fresh_ready", 64'(obs_ready), 64'(1));
    cycle(1'b0, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0, random_rd());

    // CPU drops valid while the access is waiting
    cycle(1'b1, 32'h4000_0000, 4'h0, 32'h0, 4'h0, 1'b0, random_rd());
    cycle(1'b1, 32'h4000_0000, 4'h0, 32'h0, 4'h0, 1'b0, random_rd());
    chk("ab_cs_waiting", 64'(obs_cs), 64'(4'b0010));
    cycle(1'b0, 32'h4000_0000, 4'h0, 32'h0, 4'h0, 1'b0, random_rd());
    cycle(1'b0, 32'h4000_0000, 4'h0, 32'h0, 4'h0, 1'b0, random_rd());
    chk("ab_cs_dropped", 64'(obs_cs), 64'(0));
    rdy_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 32'h0, 4'h0, 32'h0, 4'hf, 1'b0, random_rd());
      if (obs_ready) rdy_cnt++;
    end
    chk("ab_no_ready", 64'(rdy_cnt), 64'(0));
    chk("ab_no_err", 64'(obs_err_valid), 64'(0));

    // randomized traffic against the model
    rq = 1'b0; ra = '0; rws = '0; rwd = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!rq && $urandom_range(0, 2) == 0) begin
        rq  = 1'b1;
        ra  = {pick_top(), 24'($urandom)};
        rws = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
        rwd = $urandom;
      end else if (rq && $urandom_range(0, 39) == 0) begin
        rq = 1'b0;
      end
      for (int i = 0; i < NS; i++) rdy[i] = ($urandom_range(0, 3) == 0);
      ec = ($urandom_range(0, 15) == 0);
      cycle(rq, ra, rws, rwd, rdy, ec, random_rd());
      if (last_exp_ready) rq = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_bus_mux.md
Name: mmio_bus_mux

Overview:
Parametrised CPU-side memory interconnect for the application FPGA top level. It sits between the picorv32 native memory port and NUM_SLAVES target cores.
- Decodes the address against a per-slave mask/match table.
- Drives one-hot chip selects and returns a registered response.
- Adds behaviour the current fixed decoder lacks: per-access ready timeout, sticky error capture for unmapped/timed-out accesses, and abort on dropped valid.

Parameters:
NUM_SLAVES, 8, number of target ports (1..16).
ADDR_WIDTH, 15, word-address width driven to slaves (slv_address = cpu_addr[ADDR_WIDTH+1:2]).
SLAVE_MATCH, {8{8'h00}}, packed 8*NUM_SLAVES; slave i match value for cpu_addr[31:24].
SLAVE_MASK, {8{8'hff}}, packed 8*NUM_SLAVES; slave i mask applied to cpu_addr[31:24].
TIMEOUT_CYCLES, 255, maximum cycles chip select may be held without slave ready (1..2^TO_WIDTH-1).
TO_WIDTH, 8, timeout counter width.
ERR_RDATA, 32'h0, read data returned on unmapped or timed-out access.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
cpu_valid  in  1  CPU access request.
cpu_addr  in  32  byte address.
cpu_wstrb  in  4  byte write strobes; 0 = read.
cpu_wdata  in  32  write data.
cpu_ready  out  1  registered one-cycle response strobe.
cpu_rdata  out  32  registered read data, valid while cpu_ready.
slv_cs  out  NUM_SLAVES  one-hot chip selects.
slv_we  out  1  |cpu_wstrb.
slv_wstrb  out  4  cpu_wstrb passthrough.
slv_address  out  ADDR_WIDTH  cpu_addr[ADDR_WIDTH+1:2].
slv_write_data  out  32  cpu_wdata passthrough.
slv_read_data  in  32*NUM_SLAVES  packed slave read data, slave i at [32i+31:32i].
slv_ready  in  NUM_SLAVES  slave ready, sampled only for the selected slave.
err_clear  in  1  clears error capture.
err_valid  out  1  sticky: an error has been captured.
err_code  out  2  01 unmapped, 10 timeout, 00 none.
err_addr  out  32  cpu_addr of first captured error.
err_overflow  out  1  sticky: further error occurred while err_valid was set.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, all outputs 0, timeout counter 0, err_* cleared.
- Decode (combinational):
  - hit[i] = ((cpu_addr[31:24] & MASK[i]) == MATCH[i]).
  - Lowest index hit wins; no hit = unmapped.
- States: IDLE, WAIT, RESP.
- IDLE, cpu_valid=1, mapped to slave k:
  - slv_cs[k]=1 combinationally this cycle.
  - If slv_ready[k]=1: latch slave k rdata into cpu_rdata, go to RESP. cpu_ready rises the next cycle; total latency 1 cycle, matching the current top level.
  - Else: counter=1, go to WAIT.
- IDLE, cpu_valid=1, unmapped: cpu_rdata=ERR_RDATA, capture error code 01, go to RESP. Writes are discarded.
- WAIT: slv_cs[k] stays high, with k held from the registered select.
  - Ready → latch rdata, go to RESP.
  - Else if counter == TIMEOUT_CYCLES: drop cs, cpu_rdata=ERR_RDATA, capture error code 10, go to RESP.
  - Else counter+1.
- WAIT, cpu_valid=0 (protocol violation): drop cs, go to IDLE, no response, no error.
- RESP: cpu_ready=1 for exactly one cycle, no cs asserted, then go to IDLE. In this cycle cpu_valid is ignored; the next request is taken from IDLE.
- Slave outputs: slv_we, slv_wstrb, slv_address and slv_write_data always follow the CPU inputs. Only cs is gated.
- Error capture:
  - If err_valid=0: load err_code/err_addr and set err_valid.
  - If err_valid=1: keep the first error and set err_overflow.
  - err_clear clears all err_* next cycle. If a new error occurs in the same cycle as err_clear, the new error is loaded and err_overflow=0.
- At most one slv_cs bit is high in any cycle. No cs is asserted outside IDLE-with-valid and WAIT.

Test Plan:
1. Slave 0 MATCH=8'h00 MASK=8'hc0, combinational ready; read 0x0000_0010 with slv_read_data[31:0]=0x1234_5678 → slv_cs=0x01, slv_address=4, cpu_ready at cycle+1, cpu_rdata=0x1234_5678.
2. Slave 3 MATCH=8'hc3 MASK=8'hff, ready asserted 3 cycles after cs; write 0xc300_0008, wstrb=4'hf, wdata=0xcafe_f00d → slv_cs=0x08 for 4 cycles, slv_we=1, slv_address=2, slv_write_data=0xcafe_f00d, a single cpu_ready pulse.
3. TIMEOUT_CYCLES=4, slave never ready → cs high exactly 4 cycles, cpu_rdata=ERR_RDATA, err_valid=1, err_code=2'b10, err_addr=access address.
4. Read 0xc500_0000 with no match → cpu_ready at cycle+1, cpu_rdata=0, err_code=2'b01; a second unmapped access → err_overflow=1 and err_addr unchanged; err_clear → all err_* = 0.
5. Assert reset mid-WAIT → slv_cs=0 and cpu_ready=0 immediately (asynchronous); after release, a fresh access completes normally.
6. Drop cpu_valid during WAIT → cs drops the next cycle, no cpu_ready, err_valid stays 0.
